// File: rtl/four_adder.sv
// four_adder: 4-bit ripple-carry adder built from full-adder cells, with carry out,
// signed overflow and optionally registered outputs (one-cycle arithmetic stage).
module four_adder #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       ovf
);
    logic [4:0] c;
    logic [3:0] s;
    assign c[0] = c_in;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    // signed overflow: carry into the sign bit differs from carry out of it
    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum   <= 4'b0000;
                c_out <= 1'b0;
                ovf   <= 1'b0;
            end else begin
                sum   <= s;
                c_out <= c[4];
                ovf   <= c[4] ^ c[3];
            end
        end
    end else begin : g_comb
        assign sum   = s;
        assign c_out = c[4];
        assign ovf   = c[4] ^ c[3];
    end
endmodule

// File: tb/tb_four_adder.sv
// tb_four_adder: directed and exhaustive checks of four_adder, registered and
// combinational builds side by side on shared inputs.
module tb_four_adder;
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [5:0] exp;
    } vec_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       c_in = 1'b0;
    logic [3:0] sum_r, sum_c;
    logic       c_out_r, c_out_c, ovf_r, ovf_c;
    int         n_vec = 0;
    int         n_err = 0;
    vec_t       dv [6];
    four_adder #(.REG_OUT(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .sum(sum_r), .c_out(c_out_r), .ovf(ovf_r)
    );
    four_adder #(.REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .sum(sum_c), .c_out(c_out_c), .ovf(ovf_c)
    );
    always #5 clk = ~clk;
    // packed as {c_out, ovf, sum}
    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got c_out=%b ovf=%b sum=%b, want c_out=%b ovf=%b sum=%b",
                     tag, got[5], got[4], got[3:0], exp[5], exp[4], exp[3:0]);
        end
    endtask
    function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        int u, sx, sy, ss;
        u  = int'(x) + int'(y) + int'(ci);
        sx = $signed(x);
        sy = $signed(y);
        ss = sx + sy + int'(ci);
        return {u[4], (ss > 7 || ss < -8), u[3:0]};
    endfunction
    // drive at negedge, check comb path before the edge and registered path after it
    task automatic apply(input string tag, input logic [3:0] x, input logic [3:0] y,
                         input logic ci, input logic [5:0] exp);
        @(negedge clk);
        a = x;
        b = y;
        c_in = ci;
        #1 check({tag, "_comb"}, {c_out_c, ovf_c, sum_c}, exp);
        @(posedge clk);
        #1 check({tag, "_reg"}, {c_out_r, ovf_r, sum_r}, exp);
    endtask
    initial begin
        dv = '{
            '{4'b0111, 4'b0001, 1'b0, 6'b011000},
            '{4'b1000, 4'b1000, 1'b0, 6'b110000},
            '{4'b1000, 4'b1111, 1'b0, 6'b110111},
            '{4'b1111, 4'b0001, 1'b0, 6'b100000},
            '{4'b1111, 4'b1111, 1'b1, 6'b101111},
            '{4'b0111, 4'b1000, 1'b1, 6'b100000}
        };
        #1 check("reset_state", {c_out_r, ovf_r, sum_r}, 6'b000000);
        @(posedge clk);
        #1 check("reset_hold", {c_out_r, ovf_r, sum_r}, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            apply($sformatf("dir%0d", i), dv[i].a, dv[i].b, dv[i].ci, dv[i].exp);
        for (int ci = 0; ci < 2; ci++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    apply($sformatf("exh_%0d_%0d_%0d", x, y, ci), 4'(x), 4'(y), 1'(ci),
                          model(4'(x), 4'(y), 1'(ci)));
        apply("pre_rst", 4'b0011, 4'b0011, 1'b0, 6'b000110);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {c_out_r, ovf_r, sum_r}, 6'b000000);
        check("comb_ignores_rst", {c_out_c, ovf_c, sum_c}, 6'b000110);
        @(posedge clk);
        #1 check("rst_hold_edge", {c_out_r, ovf_r, sum_r}, 6'b000000);
        @(negedge clk);
        a = 4'b0010;
        b = 4'b0011;
        rst_n = 1'b1;
        #1 check("rst_release_wait", {c_out_r, ovf_r, sum_r}, 6'b000000);
        @(posedge clk);
        #1 check("rst_release_capture", {c_out_r, ovf_r, sum_r}, 6'b000101);
        @(negedge clk);
        a = 4'b0101;
        b = 4'b0010;
        c_in = 1'b0;
        #0 check("comb_zero_latency", {c_out_c, ovf_c, sum_c}, 6'b000111);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
